fdiv_sequencer: RTL
===================

FDIV_SEQUENCER -- requirements
Module: fdiv_sequencer

Interface
REQ-001 Parameter Q_DELAY, default 3, sets the number of cycles from the divider's busy falling edge to a valid div_q.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 clrn  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  operand pair present.
REQ-005 in_a, in_b  in  32 each  IEEE-754 single dividend/divisor.
REQ-006 in_ready  out  1  high only in IDLE; transfer when in_valid & in_ready.
REQ-007 stall  out  1  = in_valid | (state != IDLE); holds the issuing pipeline.
REQ-008 div_start  out  1  one-cycle request pulse to the mantissa divider.
REQ-009 div_a, div_b  out  24 each  mantissas with hidden bit, 1.23 format.
REQ-010 div_busy  in  1  divider busy.
REQ-011 div_q  in  32  quotient: q[31:30] integer bits, q[29:1] fraction, q[0] sticky.
REQ-012 out_valid  out  1  one-cycle result strobe.
REQ-013 out_z  out  32  packed single result.
REQ-014 out_dz  out  1  divide-by-zero flag, valid with out_valid.

Function
REQ-015 FSM states: IDLE, SPECIAL, ISSUE, WAIT_HI, WAIT_LO, DRAIN, ROUND, DONE.
REQ-016 IDLE accept: latch sign = a[31]^b[31], exponents, mantissas; denormal operands are flushed to signed zero at capture.
REQ-017 Special-case routing: the special case goes to SPECIAL if either operand is zero, inf or NaN, else to ISSUE.
REQ-018 SPECIAL result, resolved in one cycle, then DONE:
  - NaN operand, 0/0 or inf/inf gives 0x7FC00000.
  - Finite nonzero/0 gives signed inf with out_dz=1.
  - inf/finite gives signed inf.
  - 0/x or finite/inf gives signed zero.
REQ-019 ISSUE: div_start=1 for exactly one cycle, then WAIT_HI.
REQ-020 div_a/div_b hold constant from ISSUE until leaving WAIT_LO.
REQ-021 WAIT_HI: remain until div_busy=1, then WAIT_LO.
REQ-022 WAIT_LO: remain until div_busy=0, then DRAIN with counter = Q_DELAY.
REQ-023 DRAIN: decrement each cycle; when the counter reaches 1, capture div_q into a register and enter ROUND.
REQ-024 Exponent: e = ea - eb + 127, computed at 10-bit signed width.
REQ-025 Normalisation when q[31:30]=01: mantissa q[29:7], guard q[6], sticky |q[5:0] | q[0].
REQ-026 Normalisation when q[31:30]=00: mantissa q[28:6], guard q[5], sticky |q[4:0], and e decrements by 1.
REQ-027 Rounding: round-to-nearest-even, incrementing when guard & (sticky | lsb).
REQ-028 Rounding carry-out: mantissa becomes 0 and e increments by 1.
REQ-029 Range after rounding:
  - e >= 255 gives signed inf (0x7F800000 | sign).
  - e <= 0 gives signed zero (flush, no denormals).
REQ-030 DONE: out_valid=1 for one cycle with out_z/out_dz stable, then IDLE.
REQ-031 Throughput: no new operand is accepted before returning to IDLE; back-to-back in_valid is accepted the cycle after DONE.
REQ-032 out_z and out_dz hold their last value until the next DONE.
REQ-033 A div_busy rising edge during IDLE, SPECIAL or ROUND is ignored.

Reset
REQ-034 clrn low forces, immediately and asynchronously: state IDLE, div_start 0, out_valid 0, out_z 0, out_dz 0, DRAIN counter 0, operand registers 0.
REQ-035 Reset mid-operation abandons the result; no out_valid is produced for the in-flight operand.
REQ-036 After release, the first accepted operand behaves as after power-up.

Verification
REQ-037 3.0/1.5 (0x40400000/0x3FC00000) -> out_z 0x40000000, out_dz 0, one div_start pulse.
REQ-038 1.0/3.0 (0x3F800000/0x40400000), divider model returning exact RNE-able quotient -> out_z 0x3EAAAAAB.
REQ-039 1.0/0.0 -> out_z 0x7F800000, out_dz 1, no div_start, out_valid 2 cycles after accept.
REQ-040 0.0/0.0 -> 0x7FC00000; -2.0/inf (0xC0000000/0x7F800000) -> 0x80000000.
REQ-041 0x7E967699/0x00800000 (exponent overflow) -> 0x7F800000; 0x00800000/0x7E967699 (underflow) -> 0x00000000.
REQ-042 Assert clrn low during WAIT_LO -> no out_valid.
REQ-043 After release, 3.0/1.5 completes normally with 0x40000000.
REQ-044 stall must be high on every cycle from the accept cycle through DONE.

Source files
------------

// File: rtl/fdiv_sequencer.sv
// Single-precision divide sequencer: unpacks operands, resolves special cases locally,
// drives an external mantissa divider, then normalises, rounds (RNE) and packs the quotient.
module fdiv_sequencer #(
    parameter int Q_DELAY = 3
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        in_valid,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        in_ready,
    output logic        stall,
    output logic        div_start,
    output logic [23:0] div_a,
    output logic [23:0] div_b,
    input  logic        div_busy,
    input  logic [31:0] div_q,
    output logic        out_valid,
    output logic [31:0] out_z,
    output logic        out_dz
);

    // state   | meaning
    // IDLE    | ready for an operand pair
    // SPECIAL | zero/inf/NaN operand, result built without the divider
    // ISSUE   | one-cycle start pulse to the mantissa divider
    // WAIT_HI | waiting for the divider to report busy
    // WAIT_LO | waiting for the divider to finish
    // DRAIN   | counting down until div_q is valid, then capture it
    // ROUND   | normalise, round, range-check and pack
    // DONE    | result strobe
    typedef enum logic [2:0] {
        IDLE, SPECIAL, ISSUE, WAIT_HI, WAIT_LO, DRAIN, ROUND, DONE
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  ea_q, ea_d, eb_q, eb_d;
    logic [22:0] fa_q, fa_d, fb_q, fb_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] q_q, q_d;
    logic [31:0] z_q, z_d;
    logic        dz_q, dz_d;

    logic        in_special;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [31:0] spec_z;
    logic        spec_dz;

    logic signed [9:0] e_base, e_norm, e_rnd;
    logic [22:0] mant;
    logic        guard, sticky, inc;
    logic [23:0] mant_r;
    logic [22:0] frac_r;
    logic [31:0] round_z;

    // Exponent 0 covers both zero and denormal (flushed); exponent 255 covers inf and NaN.
    assign in_special = (in_a[30:23] == 8'h00) || (in_a[30:23] == 8'hFF) ||
                        (in_b[30:23] == 8'h00) || (in_b[30:23] == 8'hFF);

    assign a_zero = (ea_q == 8'h00);
    assign b_zero = (eb_q == 8'h00);
    assign a_inf  = (ea_q == 8'hFF) && (fa_q == 23'd0);
    assign b_inf  = (eb_q == 8'hFF) && (fb_q == 23'd0);
    assign a_nan  = (ea_q == 8'hFF) && (fa_q != 23'd0);
    assign b_nan  = (eb_q == 8'hFF) && (fb_q != 23'd0);

    always_comb begin
        spec_z  = {sign_q, 31'd0};
        spec_dz = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_z = 32'h7FC0_0000;
        end else if (a_inf) begin
            spec_z = {sign_q, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_z  = {sign_q, 8'hFF, 23'd0};
            spec_dz = 1'b1;
        end
    end

    always_comb begin
        e_base = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
        if (q_q[31] || q_q[30]) begin
            mant   = q_q[29:7];
            guard  = q_q[6];
            sticky = |q_q[5:0];
            e_norm = e_base;
        end else begin
            mant   = q_q[28:6];
            guard  = q_q[5];
            sticky = |q_q[4:0];
            e_norm = e_base - 10'sd1;
        end
        inc    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {23'd0, inc};
        if (mant_r[23]) begin
            frac_r = 23'd0;
            e_rnd  = e_norm + 10'sd1;
        end else begin
            frac_r = mant_r[22:0];
            e_rnd  = e_norm;
        end
        if (e_rnd >= 10'sd255) begin
            round_z = {sign_q, 8'hFF, 23'd0};
        end else if (e_rnd <= 10'sd0) begin
            round_z = {sign_q, 31'd0};
        end else begin
            round_z = {sign_q, e_rnd[7:0], frac_r};
        end
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        ea_d      = ea_q;
        eb_d      = eb_q;
        fa_d      = fa_q;
        fb_d      = fb_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        z_d       = z_q;
        dz_d      = dz_q;
        in_ready  = 1'b0;
        div_start = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sign_d  = in_a[31] ^ in_b[31];
                    ea_d    = in_a[30:23];
                    eb_d    = in_b[30:23];
                    fa_d    = (in_a[30:23] == 8'h00) ? 23'd0 : in_a[22:0];
                    fb_d    = (in_b[30:23] == 8'h00) ? 23'd0 : in_b[22:0];
                    state_d = in_special ? SPECIAL : ISSUE;
                end
            end
            SPECIAL: begin
                z_d     = spec_z;
                dz_d    = spec_dz;
                state_d = DONE;
            end
            ISSUE: begin
                div_start = 1'b1;
                state_d   = WAIT_HI;
            end
            WAIT_HI: begin
                if (div_busy) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!div_busy) begin
                    cnt_d   = 8'(Q_DELAY);
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q <= 8'd1) begin
                    q_d     = div_q;
                    cnt_d   = 8'd0;
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ROUND: begin
                z_d     = round_z;
                dz_d    = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ea_q    <= 8'd0;
            eb_q    <= 8'd0;
            fa_q    <= 23'd0;
            fb_q    <= 23'd0;
            cnt_q   <= 8'd0;
            q_q     <= 32'd0;
            z_q     <= 32'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            z_q     <= z_d;
            dz_q    <= dz_d;
        end
    end

    // Hidden bit follows the stored exponent so the divider sees zeros out of reset.
    assign div_a  = {(ea_q != 8'h00), fa_q};
    assign div_b  = {(eb_q != 8'h00), fb_q};
    assign stall  = in_valid | (state_q != IDLE);
    assign out_z  = z_q;
    assign out_dz = dz_q;

endmodule
